demux_1to8_reg: RTL

//  Registered 1-to-8 demultiplexer: steers one WIDTH-bit word to one of eight output slots chosen by iSelect.

---
 rtl/demux_1to8_reg.sv | 73 +++++++
 1 files changed

// File: rtl/demux_1to8_reg.sv
// Registered 1-to-8 demultiplexer: one input word is steered into one of eight
// single-entry holding slots, each drained by its own valid/ack handshake.
module demux_1to8_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [WIDTH-1:0]   iData,
  input  logic [2:0]         iSelect,
  input  logic               iValid,
  output logic               oReady,
  output logic [8*WIDTH-1:0] oData,
  output logic [7:0]         oValid,
  input  logic [7:0]         iAck,
  output logic [CNT_W-1:0]   oAccCount,
  output logic [CNT_W-1:0]   oStallCnt
);

  logic [7:0]       valid_reg;
  logic [CNT_W-1:0] acc_count_reg;
  logic [CNT_W-1:0] stall_count_reg;
  logic             accept;
  logic             stall;

  // An ack on the selected slot frees it in the same cycle, so a full slot
  // being drained can be refilled without a bubble.
  assign oReady = ~valid_reg[iSelect] | iAck[iSelect];
  assign accept = iValid & oReady;
  assign stall  = iValid & ~oReady;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_slot
      logic [WIDTH-1:0] data_reg;
      logic             load;

      assign load = accept && (iSelect == 3'(gi));

      always_ff @(posedge iCLK) begin
        if (iRST) begin
          valid_reg[gi] <= 1'b0;
          data_reg      <= '0;
        end else if (load) begin
          valid_reg[gi] <= 1'b1;
          data_reg      <= iData;
        end else if (iAck[gi]) begin
          valid_reg[gi] <= 1'b0;
        end
      end

      assign oData[gi*WIDTH +: WIDTH] = data_reg;
    end
  endgenerate

  // Accept count wraps; stall count sticks at all-ones.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      acc_count_reg   <= '0;
      stall_count_reg <= '0;
    end else begin
      if (accept)
        acc_count_reg <= acc_count_reg + 1'b1;
      if (stall && (stall_count_reg != {CNT_W{1'b1}}))
        stall_count_reg <= stall_count_reg + 1'b1;
    end
  end

  assign oValid    = valid_reg;
  assign oAccCount = acc_count_reg;
  assign oStallCnt = stall_count_reg;

endmodule
